// File: rtl/dm_pkg.sv
// Shared definitions for the handshaked data memory controller.
//   - access size encodings and exception codes as seen on the ports
//   - controller state enum
//   - wait-state counter width and the largest supported LATENCY
package dm_pkg;

  typedef enum logic [1:0] {
    SzByte = 2'b00,
    SzHalf = 2'b01,
    SzWord = 2'b10,
    SzBad  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ExcNone     = 2'b00,
    ExcMisalign = 2'b01,
    ExcRange    = 2'b10,
    ExcSize     = 2'b11
  } exc_e;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StAccess,
    StDone,
    StErr
  } state_e;

  localparam int unsigned LatencyMax = 15;
  localparam int unsigned CntW       = 4;

  // Halves must sit on even bytes, words on multiples of four.
  function automatic logic misaligned(size_e sz, logic [1:0] lo);
    return ((sz == SzHalf) && lo[0]) || ((sz == SzWord) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane datapath, purely combinational.
//   old_word_i : word currently held at the addressed location
//   wdata_i    : store data, low-order bytes used for byte/half
//   size_i     : access size (dm_pkg::size_e encoding)
//   lane_i     : addr[1:0] of the access
//   sign_i     : 1 = sign-extend loads, 0 = zero-extend
//   merged_o   : old_word_i with the store lanes replaced
//   rdata_o    : extracted and extended load data (0 for an illegal size)
module dm_lane
  import dm_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        sign_i,
  output logic [31:0] merged_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = old_word_i[8*lane_i +: 8];
    half_sel = old_word_i[16*lane_i[1] +: 16];
  end

  always_comb begin
    merged_o = old_word_i;
    unique case (size_e'(size_i))
      SzByte:  merged_o[8*lane_i +: 8]       = wdata_i[7:0];
      SzHalf:  merged_o[16*lane_i[1] +: 16]  = wdata_i[15:0];
      SzWord:  merged_o                      = wdata_i;
      default: merged_o                      = old_word_i;
    endcase
  end

  always_comb begin
    rdata_o = '0;
    unique case (size_e'(size_i))
      SzByte:  rdata_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      SzHalf:  rdata_o = {{16{sign_i & half_sel[15]}}, half_sel};
      SzWord:  rdata_o = old_word_i;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Handshaked data memory for the MEM stage.
//   clk_i, rst_ni        : clock, asynchronous active-low reset (array not cleared)
//   req_i, we_i          : request (sampled while ready_o), 1 = store
//   size_i, sign_i       : access size, load sign-extension
//   addr_i, wdata_i      : byte address, store data
//   ready_o              : idle, able to accept
//   done_o               : one-cycle completion pulse
//   rdata_o              : load data while done_o && !exc_o, else 0
//   exc_o, exc_code_o    : access rejected, with reason
module data_mem_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        exc_o,
  output logic [1:0]  exc_code_o
);

  // Out-of-range LATENCY values saturate rather than wrap the counter.
  localparam int unsigned    LatEff = (LATENCY > LatencyMax) ? LatencyMax : LATENCY;
  localparam logic [CntW-1:0] LatCnt = CntW'(LatEff);
  localparam int unsigned    Depth  = 2 ** ADDR_W;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  exc_e               exc_code_q, exc_code_d;

  logic               we_q, sign_q;
  logic [1:0]         size_q;
  logic [ADDR_W+1:0]  addr_q;
  logic [31:0]        wdata_q;

  logic               accept;
  exc_e               fault;
  logic [31:0]        mem_q [Depth];
  logic [ADDR_W-1:0]  idx;
  logic [31:0]        merged_word, load_word;
  logic               mem_we;

  assign accept = (state_q == StIdle) && req_i;
  assign idx    = addr_q[ADDR_W+1:2];
  assign mem_we = (state_q == StAccess) && we_q;

  // Fault classification on the live request, highest priority first.
  always_comb begin
    fault = ExcNone;
    if (size_e'(size_i) == SzBad) begin
      fault = ExcSize;
    end else if (misaligned(size_e'(size_i), addr_i[1:0])) begin
      fault = ExcMisalign;
    end else if (|addr_i[31:ADDR_W+2]) begin
      fault = ExcRange;
    end
  end

  dm_lane u_lane (
    .old_word_i (mem_q[idx]),
    .wdata_i    (wdata_q),
    .size_i     (size_q),
    .lane_i     (addr_q[1:0]),
    .sign_i     (sign_q),
    .merged_o   (merged_word),
    .rdata_o    (load_word)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rdata_q    <= '0;
      exc_code_q <= ExcNone;
      we_q       <= 1'b0;
      sign_q     <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      exc_code_q <= exc_code_d;
      if (accept) begin
        we_q    <= we_i;
        sign_q  <= sign_i;
        size_q  <= size_i;
        addr_q  <= addr_i[ADDR_W+1:0];
        wdata_q <= wdata_i;
      end
    end
  end

  // The array has no reset: reset must not disturb stored data.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[idx] <= merged_word;
    end
  end

  // rdata/exc_code registers default to zero so they are only non-zero in DONE/ERR.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = '0;
    exc_code_d = ExcNone;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          if (fault != ExcNone) begin
            state_d    = StErr;
            exc_code_d = fault;
          end else if (LatEff == 0) begin
            state_d = StAccess;
          end else begin
            state_d = StWait;
            cnt_d   = LatCnt;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StAccess;
        end
      end
      StAccess: begin
        state_d = StDone;
        if (!we_q) begin
          rdata_d = load_word;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_o    = (state_q == StIdle);
    done_o     = (state_q == StDone) || (state_q == StErr);
    exc_o      = (state_q == StErr);
    rdata_o    = rdata_q;
    exc_code_o = exc_code_q;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench: three controllers (LATENCY 1, 0, 15) against a behavioural model.
module tb_data_mem_ctrl;

  localparam int unsigned AW = 12;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req   [NI];
  logic        we    [NI];
  logic        sign  [NI];
  logic [1:0]  size  [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic        ready [NI];
  logic        done  [NI];
  logic        exc   [NI];
  logic [31:0] rdata [NI];
  logic [1:0]  exc_code [NI];

  data_mem_ctrl #(.ADDR_W(AW), .LATENCY(1)) u_dut_l1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .size_i(size[0]),
    .sign_i(sign[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .ready_o(ready[0]),
    .done_o(done[0]), .rdata_o(rdata[0]), .exc_o(exc[0]), .exc_code_o(exc_code[0])
  );

  data_mem_ctrl #(.ADDR_W(AW), .LATENCY(0)) u_dut_l0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .size_i(size[1]),
    .sign_i(sign[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .ready_o(ready[1]),
    .done_o(done[1]), .rdata_o(rdata[1]), .exc_o(exc[1]), .exc_code_o(exc_code[1])
  );

  data_mem_ctrl #(.ADDR_W(AW), .LATENCY(15)) u_dut_l15 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .we_i(we[2]), .size_i(size[2]),
    .sign_i(sign[2]), .addr_i(addr[2]), .wdata_i(wdata[2]), .ready_o(ready[2]),
    .done_o(done[2]), .rdata_o(rdata[2]), .exc_o(exc[2]), .exc_code_o(exc_code[2])
  );

  int checks = 0;
  int failures = 0;

  // Reference memory image per instance, word addressed.
  logic [31:0] mdl [NI][4096];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 15;
  endfunction

  function automatic logic [1:0] mdl_code(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 2'b11;
    if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) return 2'b01;
    if ((a >> (AW + 2)) != 0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] mdl_mask(input logic [1:0] sz);
    return (sz == 2'b00) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic int mdl_shift(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b00) ? 8 * int'(a[1:0]) : (sz == 2'b01) ? 16 * int'(a[1]) : 0;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] word, input logic [1:0] sz,
                                           input logic sg, input logic [31:0] a);
    logic [31:0] v;
    logic [31:0] m;
    m = mdl_mask(sz);
    v = (word >> mdl_shift(sz, a)) & m;
    if (sg && sz == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
    if (sg && sz == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // One transaction: request held through the whole busy period, outputs checked every cycle.
  task automatic do_op(input int k, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] got_rdata, output logic [1:0] got_code);
    int budget;
    int n;
    int idx;
    logic [1:0]  code;
    logic [31:0] exp_r;
    logic [31:0] m;
    int sh;
    budget = 0;
    @(negedge clk);
    while (ready[k] !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    chk("ready_before_req", 32'(ready[k]), 32'd1);
    chk("done_before_req", 32'(done[k]), 32'd0);
    we[k] = w; size[k] = sz; sign[k] = sg; addr[k] = a; wdata[k] = wd; req[k] = 1'b1;
    code  = mdl_code(sz, a);
    idx   = int'(a[AW+1:2]);
    n     = (code != 2'b00) ? 1 : lat_of(k) + 2;
    exp_r = 32'h0;
    if (code == 2'b00) begin
      if (w) begin
        m  = mdl_mask(sz);
        sh = mdl_shift(sz, a);
        mdl[k][idx] = (mdl[k][idx] & ~(m << sh)) | ((wd & m) << sh);
      end else begin
        exp_r = mdl_load(mdl[k][idx], sz, sg, a);
      end
    end
    got_rdata = 32'h0;
    got_code  = 2'b00;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c < n) begin
        chk("busy_ready", 32'(ready[k]), 32'd0);
        chk("busy_done", 32'(done[k]), 32'd0);
      end else begin
        chk("done_pulse", 32'(done[k]), 32'd1);
        chk("exc", 32'(exc[k]), 32'(code != 2'b00));
        chk("exc_code", 32'(exc_code[k]), 32'(code));
        chk("rdata", rdata[k], exp_r);
        chk("ready_at_done", 32'(ready[k]), 32'd0);
        got_rdata = rdata[k];
        got_code  = exc_code[k];
      end
    end
    req[k] = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(ready[k]), 32'd1);
    chk("idle_done", 32'(done[k]), 32'd0);
    chk("idle_exc", 32'(exc[k]), 32'd0);
    chk("idle_rdata", rdata[k], 32'h0);
  endtask

  task automatic chk_reset_vals(input int k);
    chk("rst_ready", 32'(ready[k]), 32'd1);
    chk("rst_done", 32'(done[k]), 32'd0);
    chk("rst_exc", 32'(exc[k]), 32'd0);
    chk("rst_code", 32'(exc_code[k]), 32'd0);
    chk("rst_rdata", rdata[k], 32'h0);
  endtask

  task automatic rand_ops(input int k, input int count);
    logic [31:0] r;
    logic [1:0]  c;
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < count; i++) begin
      a  = ($urandom % 64) * 4 + ($urandom % 4);
      if ($urandom % 10 == 0) a = a | (32'h1 << (14 + ($urandom % 18)));
      sz = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
      do_op(k, 1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom, r, c);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0]  c;
    for (int k = 0; k < NI; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; sign[k] = 1'b0; size[k] = 2'b00;
      addr[k] = 32'h0; wdata[k] = 32'h0;
      for (int i = 0; i < 4096; i++) mdl[k][i] = 32'h0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) chk_reset_vals(k);
    rst_n = 1'b1;

    // Directed sequence, LATENCY = 1, with literal expectations pinning the model.
    do_op(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h1234_5678, r, c);
    do_op(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, r, c);  chk("lw_100_a", r, 32'h1234_5678);
    do_op(0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00AB, r, c);
    do_op(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, r, c);  chk("lw_100_b", r, 32'h1234_AB78);
    do_op(0, 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, r, c);  chk("lb_101", r, 32'hFFFF_FFAB);
    do_op(0, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, r, c);  chk("lbu_101", r, 32'h0000_00AB);
    do_op(0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_8001, r, c);
    do_op(0, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, r, c);  chk("lh_102", r, 32'hFFFF_8001);
    do_op(0, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, r, c);  chk("lhu_102", r, 32'h0000_8001);
    do_op(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, r, c);  chk("lw_100_c", r, 32'h8001_AB78);
    do_op(0, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, r, c);  chk("lw_mis_code", 32'(c), 32'd1);
    do_op(0, 1'b1, 2'b10, 1'b0, 32'h4000, 32'hFFFF_FFFF, r, c);
    chk("sw_range_code", 32'(c), 32'd2);
    do_op(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, r, c);    chk("lw_0_untouched", r, 32'h0);
    do_op(0, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, r, c);  chk("size11_code", 32'(c), 32'd3);
    do_op(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, r, c);  chk("lw_100_d", r, 32'h8001_AB78);

    // Reset during WAIT of a store: nothing committed, outputs back to reset values at once.
    @(negedge clk);
    chk("pre_rst_ready", 32'(ready[0]), 32'd1);
    we[0] = 1'b1; size[0] = 2'b10; sign[0] = 1'b0; addr[0] = 32'h200;
    wdata[0] = 32'hDEAD_BEEF; req[0] = 1'b1;
    @(negedge clk);
    chk("wait_busy", 32'(ready[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals(0);
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, r, c);  chk("lw_200_after_rst", r, 32'h0);

    rand_ops(0, 300);

    // LATENCY = 0 and 15: timing comes from the per-cycle checks in do_op.
    do_op(1, 1'b1, 2'b10, 1'b0, 32'h040, 32'hCAFE_F00D, r, c);
    do_op(1, 1'b0, 2'b01, 1'b1, 32'h042, 32'h0, r, c);  chk("l0_lh_042", r, 32'hFFFF_CAFE);
    do_op(1, 1'b0, 2'b00, 1'b0, 32'h043, 32'h0, r, c);  chk("l0_lbu_043", r, 32'h0000_00CA);
    rand_ops(1, 40);
    do_op(2, 1'b1, 2'b00, 1'b0, 32'h3FFF, 32'h0000_0080, r, c);
    do_op(2, 1'b0, 2'b00, 1'b1, 32'h3FFF, 32'h0, r, c); chk("l15_lb_top", r, 32'hFFFF_FF80);
    do_op(2, 1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0, r, c); chk("l15_lw_top", r, 32'h8000_0000);
    rand_ops(2, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #5_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, handshaked successor to the single-cycle data memory in the pipeline's MEM stage. Accepts byte/half/word loads and stores through a req/ready handshake, models a configurable number of wait states, performs byte-lane merge and sign/zero extension internally, and flags misaligned and out-of-range accesses instead of silently wrapping. The MEM stage stalls on `ready`/`done`; exceptions feed the CP0 path.

## Interface
- `ADDR_W`, default 12: word-address bits; depth = 2^ADDR_W words of 32 bits.
- `LATENCY`, default 1: wait cycles between accept and array access, legal 0..15.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: reset is asynchronous and active-low; clears FSM, counter and outputs, not array contents.
- `req` in 1: access request, sampled only when `ready`=1.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `sign` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `addr` in 32: byte address.
- `wdata` in 32: store data, low-order bytes used for byte/half.
- `ready` out 1: controller idle and able to accept.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load data, valid only while `done`=1 and `exc`=0; 0 otherwise.
- `exc` out 1: with `done`, access rejected.
- `exc_code` out 2: 01 misaligned, 10 out of range, 11 illegal size, 00 none.

## Operation
- States: IDLE, WAIT, ACCESS, DONE, ERR.
- IDLE: `ready`=1. On `req`, latch `we`, `size`, `sign`, `addr`, `wdata`.
- At accept, check in priority order: size 11 -> code 11; half with addr[0]=1, or word with addr[1:0]!=0 -> code 01; addr[31:ADDR_W+2]!=0 -> code 10. Any fault -> ERR.
- No fault: go to WAIT with counter = LATENCY. If LATENCY = 0, go straight to ACCESS.
- WAIT: decrement the counter; on reaching 0, go to ACCESS.
- ACCESS: index = addr[ADDR_W+1:2]. Store: read-modify-write with byte enables, committed on this edge. Byte lane = addr[1:0]; half lane = addr[1]. Load: extract lane, extend per `sign`, register into `rdata`. Then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- ERR: `done`=1, `exc`=1, `exc_code` set, for one cycle. No array write. `rdata`=0. Then IDLE.
- `req` while not ready is ignored; the requester must hold it.
- Reset mid-operation: abort; a pending store is not committed; return to IDLE.
- Array is zero at simulation start.

## Timing
- Reset values: `ready`=1, `done`=0, `exc`=0, `exc_code`=00, `rdata`=0, state IDLE.
- Accept at edge E0. Array access at edge E(LATENCY+1). `done` is high in the cycle after that edge. Next accept is possible at edge E(LATENCY+3).
- Fault path: `done`/`exc` are high in the cycle after E0. Next accept at E2.
- Load-after-store to the same word returns the new data; accesses are serialised, so no hazard exists.

## Structure
- Package `dm_pkg` holds: size encodings, exc_code values, state enum, and a LATENCY range check constant.
- Sub-module `dm_lane` is combinational. It does store merge (old word, wdata, size, addr[1:0] -> new word) and load extract/extend (word, size, sign, addr[1:0] -> rdata). It is reused by the future cache fill path.

## Test plan
- LATENCY=1. `sw` 0x12345678 to 0x100, then `lw` 0x100 -> `rdata`=0x12345678. `done` appears 2 cycles after each accept.
- `sb` 0xAB to 0x101 over the stored word, then `lw` 0x100 -> 0x1234AB78. `lb` 0x101 sign=1 -> 0xFFFFFFAB. `lbu` -> 0x000000AB.
- `sh` 0x8001 to 0x102, then `lh` 0x102 -> 0xFFFF8001. `lhu` -> 0x00008001. `lw` 0x100 -> 0x8001AB78.
- `lw` at 0x102 -> `exc`=1, code 01, no write. `sw` at 0x4000 with ADDR_W=12 -> code 10, and memory at 0x0 is unchanged. size=11 -> code 11.
- LATENCY=0 and LATENCY=15: `done` arrives exactly 1 and 16 cycles after accept; `req` held during busy is not double-accepted.
- Assert `reset` low during WAIT of an `sw` 0xDEADBEEF to 0x200 -> outputs return to reset values immediately; a later `lw` 0x200 returns 0.
